// File: rtl/mask_pkg.sv
// mask_pkg: helpers shared by the Boolean masking blocks and their benches.
// share_t is provided as a macro so each user can size it to its own width.
`define MASK_SHARE_T(W) typedef logic [(W)-1:0] share_t;

package mask_pkg;

  function automatic int f_randnum(input int n);
    return n - 1;
  endfunction

  function automatic int f_split_lat(input int n);
    return (n == 1) ? 1 : n - 1;
  endfunction

endpackage

// File: rtl/mask_stage.sv
// mask_stage: one register step of the share-splitting pipeline.
// Folds a single fresh word into the accumulator and carries randomness along.
module mask_stage #(
  parameter int K_WIDTH = 32,
  parameter int P_WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ena,
  input  logic               vld_in,
  input  logic [K_WIDTH-1:0] acc_in,
  input  logic [K_WIDTH-1:0] r_in,
  input  logic [P_WIDTH-1:0] pass_in,
  output logic               vld,
  output logic [K_WIDTH-1:0] acc,
  output logic [P_WIDTH-1:0] pass
);

  // exactly one two-input XOR feeds the accumulator register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld  <= 1'b0;
      acc  <= '0;
      pass <= '0;
    end else if (ena) begin
      vld  <= vld_in;
      acc  <= acc_in ^ r_in;
      pass <= pass_in;
    end
  end

endmodule

// File: rtl/bool_mask_split.sv
// bool_mask_split: splits one plain word into N_SHARES Boolean shares.
// Share 0 is built by a registered XOR chain; shares 1.. are the random words.
module bool_mask_split
  import mask_pkg::*;
#(
  parameter int  K_WIDTH   = 32,
  parameter int  N_SHARES  = 5,
  localparam int MASKWIDTH = K_WIDTH * N_SHARES,
  localparam int RANDNUM   = f_randnum(N_SHARES),
  localparam int LAT       = f_split_lat(N_SHARES),
  localparam int RWIDTH    = ((RANDNUM > 0) ? RANDNUM : 1) * K_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ena,
  input  logic                 dvld,
  input  logic [K_WIDTH-1:0]   i_x,
  input  logic [RWIDTH-1:0]    rnd,
  output logic [MASKWIDTH-1:0] o_z,
  output logic                 ovld
);

  `MASK_SHARE_T(K_WIDTH)

  share_t            acc  [0:LAT];
  logic [RWIDTH-1:0] pass [0:LAT];
  logic              v    [0:LAT];

  assign acc[0]  = i_x;
  assign pass[0] = rnd;
  assign v[0]    = dvld;

  for (genvar s = 1; s <= LAT; s++) begin : g_stage
    share_t r_in;

    if (RANDNUM > 0) begin : g_r
      assign r_in = pass[s-1][(s-1)*K_WIDTH +: K_WIDTH];
    end else begin : g_nr
      assign r_in = '0;
    end

    mask_stage #(
      .K_WIDTH (K_WIDTH),
      .P_WIDTH (RWIDTH)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .ena     (ena),
      .vld_in  (v[s-1]),
      .acc_in  (acc[s-1]),
      .r_in    (r_in),
      .pass_in (pass[s-1]),
      .vld     (v[s]),
      .acc     (acc[s]),
      .pass    (pass[s])
    );
  end

  if (N_SHARES == 1) begin : g_one
    assign o_z = acc[LAT];
  end else begin : g_many
    assign o_z = {pass[LAT], acc[LAT]};
  end

  assign ovld = v[LAT];

endmodule
